// File: rtl/signed_sar_search.sv
// Successive-approximation search that recovers a hidden signed 4-bit value
// from an external comparator's eq/gt/lt feedback, one offset-binary bit per trial.
module signed_sar_search (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       aeqb,
  input  logic       agtb,
  input  logic       altb,
  output logic [3:0] probe,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic       err,
  output logic [3:0] result
);

  // Request/completion protocol: start is a level request, accepted only in IDLE;
  // done pulses for one cycle, with found/err/result valid in that same cycle and
  // held until the next accepted start. There is no backpressure on done.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TRIAL  = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [1:0] k_q, k_d;
  logic       found_q, found_d;
  logic       err_q, err_d;
  logic [3:0] result_q, result_d;

  logic [3:0] trial;
  logic       one_hot;

  assign trial   = acc_q | (4'b0001 << k_q);
  assign one_hot = (aeqb & ~agtb & ~altb) | (~aeqb & agtb & ~altb) | (~aeqb & ~agtb & altb);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    k_d      = k_q;
    found_d  = found_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = 4'b0000;
          k_d     = 2'd3;
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_TRIAL;
        end
      end
      S_TRIAL: begin
        if (!one_hot) begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = 4'b0000;
          state_d  = S_DONE;
        end else if (aeqb) begin
          result_d = trial ^ 4'b1000;
          found_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          // Probe below target means the trial bit belongs in the answer.
          if (altb) acc_d = trial;
          if (k_q == 2'd0) state_d = S_VERIFY;
          else             k_d = k_q - 2'd1;
        end
      end
      S_VERIFY: begin
        // Code 0000 (-8) is never probed during trials, so confirm the final code.
        if (one_hot && aeqb) begin
          result_d = acc_q ^ 4'b1000;
          found_d  = 1'b1;
        end else begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = 4'b0000;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= 4'b0000;
      k_q      <= 2'd0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    probe = 4'b0000;
    if (state_q == S_TRIAL)  probe = trial ^ 4'b1000;
    if (state_q == S_VERIFY) probe = acc_q ^ 4'b1000;
  end

  assign busy   = (state_q == S_TRIAL) || (state_q == S_VERIFY);
  assign done   = (state_q == S_DONE);
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: doc/signed_sar_search.md
# signed_sar_search

Sequential successive-approximation search engine that recovers an unknown signed 4-bit two's-complement value using only relational feedback from an external signed comparator. It drives a probe value into the comparator's `a` input, with the hidden target on `b`. It then samples `aeqb`/`agtb`/`altb` on each trial and narrows the range −8..+7 one offset-binary bit per cycle. It is the consumer-side counterpart of the signed 4-bit comparator: relations in, value out.

## Interface
Parameters: none; the width is fixed at 4 bits, signed two's-complement.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a search; sampled only in IDLE.
- `aeqb`  in  1  comparator result, probe == target.
- `agtb`  in  1  comparator result, probe > target (signed).
- `altb`  in  1  comparator result, probe < target (signed).
- `probe`  out  4  value presented to the comparator.
- `busy`  out  1  high in TRIAL and VERIFY.
- `done`  out  1  one-cycle completion pulse.
- `found`  out  1  valid with `done`; result is trustworthy.
- `err`  out  1  valid with `done`; comparator feedback was inconsistent.
- `result`  out  4  recovered target; held until the next accepted `start`.

## Operation
- States: IDLE, TRIAL, VERIFY, DONE.
- Internal registers: `acc[3:0]` holds the offset-binary accumulator (value XOR 4'b1000). `k[1:0]` holds the trial bit index.
- Trial code: t = acc | (1<<k). Probe = t ^ 4'b1000 in TRIAL and acc ^ 4'b1000 in VERIFY. Probe = 0000 in IDLE and DONE.
- IDLE: when `start`=1, clear acc to 0000, set k=3, clear found/err, go to TRIAL. When `start`=0, stay.
- TRIAL, evaluated at each edge:
  - Comparator flags not exactly one-hot: err=1, found=0, result=0000, go to DONE.
  - aeqb: result=probe, found=1, go to DONE (early exit).
  - altb: acc=t (keep bit).
  - agtb: acc unchanged (drop bit).
  - If no early exit: when k=0 go to VERIFY, else decrement k.
- VERIFY exists because the code 0000 (−8) is never probed during TRIAL. At the edge:
  - aeqb with one-hot flags: result=acc^1000, found=1.
  - Otherwise: err=1, found=0, result=0000.
  - In both cases go to DONE.
- DONE: `done`=1 for exactly one cycle, then unconditionally return to IDLE.
- `start` outside IDLE is ignored, including in DONE; it is not queued.
- Comparator inputs are combinational from `probe`. They are sampled only at the edge ending a TRIAL or VERIFY cycle.

## Timing
- Reset, asynchronous while `rst_n`=0: state=IDLE, probe=0000, busy=0, done=0, found=0, err=0, result=0000, acc=0000, k=0.
- Reset mid-search: the search is abandoned immediately and no `done` is produced. After release, the block needs a fresh `start`.
- Cycle numbering: `start` sampled at edge E0. TRIAL k=3 occupies cycle 1 (after E0), k=2 cycle 2, k=1 cycle 3, k=0 cycle 4, VERIFY cycle 5.
- `done` is high in the cycle after the deciding edge.
- Worst-case latency: `done` is high in cycle 6 after E0. An early equality exit at trial n (n=1..4) puts `done` in cycle n+1.
- `busy` is high exactly in the TRIAL/VERIFY cycles and low during DONE.
- found/err/result update at the deciding edge, so they are valid together with `done`. They hold afterwards until the next accepted `start` clears found/err.
- Back-to-back searches: `start` held high is re-accepted in IDLE. The minimum spacing from one `done` to the next accepted `start` sample is one cycle.

## Test plan
- Target +5: probes 0, 4, 6, 5. Feedback is lt, lt, gt, eq. Expect `done` in cycle 5, found=1, result=0101, err=0.
- Target −8: probes 0, −4, −6, −7, then VERIFY probe −8 (1000) with eq. Expect `done` in cycle 6, result=1000, found=1.
- Target 0: first probe 0000 returns eq. Expect `done` in cycle 2, result=0000, busy high for 1 cycle only.
- Target +7: probes 0, 4, 6, 7, with eq at trial 4. Expect result=0111. Then hold `start` high and confirm the immediate second search repeats the identical probe sequence.
- Inconsistent comparator (agtb=altb=1) on trial 2: expect `done` next cycle with err=1, found=0, result=0000. Separately, a comparator that never asserts eq must produce err=1 after VERIFY.
- Drop `rst_n` during trial 3: expect all outputs 0 and probe=0000 asynchronously, and no `done`. Pulse `start` during busy and during DONE: it must be ignored.
